// File: rtl/xoodoo_rdi_prng_if.sv
// Randomness bus between the xorshift PRNG and the masked Xoodoo round:
// seed stream in, 32*LANES-bit fresh word out, consumption strobe back.
interface xoodoo_rdi_prng_if #(
   parameter int LANES = 12
);
   logic [31:0]         seed;
   logic                seed_valid;
   logic                seed_ready;
   logic                reseed;
   logic [32*LANES-1:0] rdi;
   logic                rdi_valid;
   logic                rdi_en;
   logic [31:0]         rdi_cnt;

   modport master (
      output seed, seed_valid, reseed, rdi_en,
      input  seed_ready, rdi, rdi_valid, rdi_cnt
   );

   modport slave (
      input  seed, seed_valid, reseed, rdi_en,
      output seed_ready, rdi, rdi_valid, rdi_cnt
   );
endinterface

// File: rtl/xoodoo_rdi_prng.sv
// Fresh-randomness source for the masked Xoodoo datapath: LANES independent
// xorshift32 lanes, seeded word-by-word, optional warm-up, advanced on consumption.
//
// state  | meaning
// S_SEED | accepting seed words into lane[word_cnt]; seed_ready=1
// S_WARM | all lanes advance every cycle for WARMUP cycles, no output
// S_RUN  | rdi_valid=1; each rdi_en advances all lanes once
module xoodoo_rdi_prng #(
   parameter int LANES  = 12,
   parameter int WARMUP = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   xoodoo_rdi_prng_if.slave  bus
);

   localparam int WCW = (LANES  > 2) ? $clog2(LANES)  : 1;
   localparam int TCW = (WARMUP > 2) ? $clog2(WARMUP) : 1;

   typedef enum logic [1:0] {S_SEED, S_WARM, S_RUN} state_t;

   state_t          state, state_nxt;
   logic [WCW-1:0]  word_cnt;
   logic [TCW-1:0]  warm_cnt;
   logic [31:0]     lane [LANES];
   logic [31:0]     rdi_cnt;
   logic [31:0]     seed_word;
   logic            load, consume, adv, last_word, last_warm;

   function automatic logic [31:0] xs_step(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   assign last_word = (word_cnt == WCW'(LANES - 1));
   assign last_warm = (warm_cnt == TCW'(WARMUP - 1));
   assign load      = (state == S_SEED) && bus.seed_valid && !bus.reseed;
   assign consume   = (state == S_RUN) && bus.rdi_en;
   // a reseed freezes the lanes even when the same cycle consumes a word
   assign adv       = !bus.reseed && ((state == S_WARM) || consume);
   // zero is the xorshift fixed point, so never let a lane start there
   assign seed_word = (bus.seed == 32'h0) ? (32'h9E37_79B9 ^ 32'(word_cnt)) : bus.seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_SEED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.reseed) begin
         state_nxt = S_SEED;
      end else begin
         case (state)
            S_SEED:  if (load && last_word) state_nxt = (WARMUP > 0) ? S_WARM : S_RUN;
            S_WARM:  if (last_warm) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_SEED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         warm_cnt <= '0;
      end else if (bus.reseed) begin
         word_cnt <= '0;
         warm_cnt <= '0;
      end else begin
         if (load) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
         if (state == S_WARM) warm_cnt <= last_warm ? '0 : warm_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          rdi_cnt <= '0;
      else if (consume && rdi_cnt != '1)   rdi_cnt <= rdi_cnt + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) lane[i] <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (adv)                                  lane[i] <= xs_step(lane[i]);
            else if (load && word_cnt == WCW'(i))     lane[i] <= seed_word;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_rdi
      assign bus.rdi[32*g +: 32] = lane[g];
   end

   assign bus.seed_ready = (state == S_SEED);
   assign bus.rdi_valid  = (state == S_RUN);
   assign bus.rdi_cnt    = rdi_cnt;

endmodule

// File: tb/tb_xoodoo_rdi_prng.sv
// Bench for xoodoo_rdi_prng: one instance without warm-up, one with WARMUP=16;
// expected words are queued at stimulus time and popped by a negedge monitor.
module tb_xoodoo_rdi_prng;
   localparam int L = 12;
   localparam int W = 32 * L;

   typedef struct {
      logic [W-1:0] rdi;
      logic [31:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   xoodoo_rdi_prng_if #(.LANES(L)) bus0 ();
   xoodoo_rdi_prng_if #(.LANES(L)) bus1 ();

   xoodoo_rdi_prng #(.LANES(L), .WARMUP(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   xoodoo_rdi_prng #(.LANES(L), .WARMUP(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic [31:0]  seed_d [2];
   logic         sv_d   [2];
   logic         rs_d   [2];
   logic         en_d   [2];
   logic [W-1:0] rdi_o  [2];
   logic         v_o    [2];
   logic         rdy_o  [2];
   logic [31:0]  cnt_o  [2];

   assign bus0.seed = seed_d[0];  assign bus1.seed = seed_d[1];
   assign bus0.seed_valid = sv_d[0];  assign bus1.seed_valid = sv_d[1];
   assign bus0.reseed = rs_d[0];  assign bus1.reseed = rs_d[1];
   assign bus0.rdi_en = en_d[0];  assign bus1.rdi_en = en_d[1];
   assign rdi_o[0] = bus0.rdi;  assign rdi_o[1] = bus1.rdi;
   assign v_o[0] = bus0.rdi_valid;  assign v_o[1] = bus1.rdi_valid;
   assign rdy_o[0] = bus0.seed_ready;  assign rdy_o[1] = bus1.seed_ready;
   assign cnt_o[0] = bus0.rdi_cnt;  assign cnt_o[1] = bus1.rdi_cnt;

   int errors = 0;
   int checks = 0;

   exp_t q0[$];
   exp_t q1[$];

   logic         prev_v [2];
   logic         took   [2];
   logic [W-1:0] last_rdi [2];
   logic [31:0]  last_cnt [2];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] f(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   function automatic logic [31:0] f_n(input logic [31:0] x, input int n);
      logic [31:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = f(y);
      return y;
   endfunction

   function automatic logic [W-1:0] all_lanes(input logic [31:0] v);
      return {L{v}};
   endfunction

   task automatic push_exp(input int k, input logic [W-1:0] r, input logic [31:0] c);
      exp_t e;
      e.rdi = r;
      e.cnt = c;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int k);
      exp_t e;
      int   n;
      if (!rst_n) begin
         prev_v[k] = 1'b0;
         took[k]   = 1'b0;
         return;
      end
      if (v_o[k]) begin
         if (!prev_v[k] || took[k]) begin
            n = (k == 0) ? q0.size() : q1.size();
            if (n == 0) begin
               checks++;
               errors++;
               $display("FAIL mon%0d_unexpected: got word %h, required none", k, rdi_o[k]);
            end else begin
               if (k == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("mon%0d_rdi", k), rdi_o[k], e.rdi);
               chk($sformatf("mon%0d_cnt", k), W'(cnt_o[k]), W'(e.cnt));
               last_rdi[k] = e.rdi;
               last_cnt[k] = e.cnt;
            end
         end else begin
            chk($sformatf("mon%0d_hold_rdi", k), rdi_o[k], last_rdi[k]);
            chk($sformatf("mon%0d_hold_cnt", k), W'(cnt_o[k]), W'(last_cnt[k]));
         end
      end
      took[k]   = v_o[k] && en_d[k];
      prev_v[k] = v_o[k];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic send_seeds(input int k, input logic [31:0] w [L]);
      for (int i = 0; i < L; i++) begin
         seed_d[k] = w[i];
         sv_d[k]   = 1'b1;
         @(posedge clk); #1;
      end
      sv_d[k] = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s%0d_ready", tag, k), W'(rdy_o[k]), W'(1'b1));
         chk($sformatf("%s%0d_valid", tag, k), W'(v_o[k]), W'(1'b0));
         chk($sformatf("%s%0d_rdi", tag, k), rdi_o[k], '0);
         chk($sformatf("%s%0d_cnt", tag, k), W'(cnt_o[k]), '0);
      end
   endtask

   task automatic wait_warm(input string tag);
      int n;
      n = 0;
      while (!v_o[1] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, W'(n), W'(16));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  ones [L];
      logic [31:0]  twos [L];
      logic [31:0]  w3 [L];
      logic [W-1:0] e3;
      logic [31:0]  m;

      for (int k = 0; k < 2; k++) begin
         seed_d[k] = '0; sv_d[k] = 1'b0; rs_d[k] = 1'b0; en_d[k] = 1'b0;
         prev_v[k] = 1'b0; took[k] = 1'b0; last_rdi[k] = '0; last_cnt[k] = '0;
      end
      for (int i = 0; i < L; i++) begin
         ones[i] = 32'h1;
         twos[i] = 32'h2;
         w3[i]   = 32'(i + 1);
      end
      w3[3] = 32'h0;
      e3 = '0;
      for (int i = 0; i < L; i++) e3[32*i +: 32] = w3[i];
      e3[32*3 +: 32] = 32'h9E37_79BA;

      rst_n = 1'b0;
      #12;
      check_reset_vals("rst");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // all-ones seeding without warm-up
      push_exp(0, all_lanes(32'h1), 32'd0);
      send_seeds(0, ones);
      chk("t1_ready_low", W'(rdy_o[0]), W'(1'b0));
      chk("t1_valid_high", W'(v_o[0]), W'(1'b1));

      // single consumption then idle hold
      push_exp(0, all_lanes(32'h0004_2021), 32'd1);
      en_d[0] = 1'b1;
      @(posedge clk); #1;
      en_d[0] = 1'b0;
      repeat (6) begin @(posedge clk); #1; end

      // back-to-back consumption
      m = 32'h0004_2021;
      for (int j = 0; j < 3; j++) begin
         m = f(m);
         push_exp(0, all_lanes(m), 32'(2 + j));
      end
      en_d[0] = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      en_d[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      m = f_n(32'h1, 4);

      // reseed together with rdi_en: counted, lanes frozen
      rs_d[0] = 1'b1; en_d[0] = 1'b1;
      @(posedge clk); #1;
      rs_d[0] = 1'b0; en_d[0] = 1'b0;
      chk("t5_cnt", W'(cnt_o[0]), W'(32'd5));
      chk("t5_valid", W'(v_o[0]), W'(1'b0));
      chk("t5_ready", W'(rdy_o[0]), W'(1'b1));
      chk("t5_lanes", rdi_o[0], all_lanes(m));
      repeat (3) begin @(posedge clk); #1; end
      chk("t5_lanes_held", rdi_o[0], all_lanes(m));

      // partial seeding, then reseed with a word that must be dropped
      seed_d[0] = 32'hDEAD_0000; sv_d[0] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("t5_lane2_untouched", W'(rdi_o[0][95:64]), W'(m));
      chk("t5_lane1_loaded", W'(rdi_o[0][63:32]), W'(32'hDEAD_0000));
      seed_d[0] = 32'h0000_BEEF; rs_d[0] = 1'b1;
      @(posedge clk); #1;
      rs_d[0] = 1'b0; sv_d[0] = 1'b0;
      push_exp(0, e3, 32'd5);
      send_seeds(0, w3);
      chk("t3_valid", W'(v_o[0]), W'(1'b1));

      // warm-up instance
      push_exp(1, all_lanes(f_n(32'h1, 16)), 32'd0);
      send_seeds(1, ones);
      chk("t4_warm_valid", W'(v_o[1]), W'(1'b0));
      chk("t4_warm_ready", W'(rdy_o[1]), W'(1'b0));
      wait_warm("t4_warm_cycles");

      // async reset in the middle of warm-up
      rs_d[1] = 1'b1;
      @(posedge clk); #1;
      rs_d[1] = 1'b0;
      chk("t6_ready", W'(rdy_o[1]), W'(1'b1));
      send_seeds(1, twos);
      repeat (5) begin @(posedge clk); #1; end
      #3 rst_n = 1'b0;
      #1;
      check_reset_vals("t6_async");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rs_d[1] = 1'b1;
      @(posedge clk); #1;
      rs_d[1] = 1'b0;
      push_exp(1, all_lanes(f_n(32'h1, 16)), 32'd0);
      send_seeds(1, ones);
      wait_warm("t6_warm_cycles");

      repeat (3) begin @(posedge clk); #1; end
      chk("q0_drained", W'(q0.size()), '0);
      chk("q1_drained", W'(q1.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
